// File: rtl/iob_skid_reg_n.sv
// iob_skid_reg_n: two-entry ready/valid skid buffer with fully registered
// forward (valid/data) and backward (ready) paths. The only combinational
// term on the outputs is the clock-enable gating of valid and ready.
//
// Optional feature: define IOB_SKID_REG_N_FLUSH_EN to add a synchronous
// active-high flush_i port that empties the buffer (data registers are
// left untouched). Without the macro the port and its logic are absent.

module iob_skid_reg_n #(
    parameter int                DATA_W  = 21,
    parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cke_i,
`ifdef IOB_SKID_REG_N_FLUSH_EN
    input  logic              flush_i,
`endif
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o
);

    // Encoding mirrors the valid bits: bit0 = main_v, bit1 = skid_v.
    // 2'b10 (skid without main) is unreachable and recovers to EMPTY.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              ready_r;
    logic [DATA_W-1:0] main_data_r;
    logic [DATA_W-1:0] skid_data_r;

    logic              main_v_s;
    logic              in_xfer_s;
    logic              out_xfer_s;
    logic              flush_s;
    logic              load_main_s;
    logic              load_skid_s;
    logic              main_from_skid_s;

`ifdef IOB_SKID_REG_N_FLUSH_EN
    assign flush_s = flush_i;
`else
    assign flush_s = 1'b0;
`endif

    // Handshake qualification: both transfers already carry the cke gating
    // through the gated output strobes.
    always_comb begin
        in_xfer_s  = s_valid_i & s_ready_o;
        out_xfer_s = m_valid_o & m_ready_i;
    end

    // Next-state and data-load decode for the occupancy FSM.
    always_comb begin
        state_nxt_s      = state_r;
        load_main_s      = 1'b0;
        load_skid_s      = 1'b0;
        main_from_skid_s = 1'b0;
        if (!cke_i) begin
            state_nxt_s = state_r;
        end else if (flush_s) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        state_nxt_s = ST_ONE;
                        load_main_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_xfer_s && !out_xfer_s) begin
                        state_nxt_s = ST_FULL;
                        load_skid_s = 1'b1;
                    end else if (in_xfer_s && out_xfer_s) begin
                        state_nxt_s = ST_ONE;
                        load_main_s = 1'b1;
                    end else if (out_xfer_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    // Ready is low in FULL, so only the output side can move.
                    if (out_xfer_s) begin
                        state_nxt_s      = ST_ONE;
                        load_main_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State and registered ready: ready_r tracks "skid will be empty".
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_r <= ST_EMPTY;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s != ST_FULL);
        end
    end

    // Data registers: main refills from skid on drain, otherwise from input.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            main_data_r <= RST_VAL;
            skid_data_r <= RST_VAL;
        end else begin
            if (load_main_s) begin
                main_data_r <= main_from_skid_s ? skid_data_r : s_data_i;
            end else begin
                main_data_r <= main_data_r;
            end
            if (load_skid_s) begin
                skid_data_r <= s_data_i;
            end else begin
                skid_data_r <= skid_data_r;
            end
        end
    end

    // Output decode: registered state gated only by the clock enable.
    always_comb begin
        main_v_s  = (state_r == ST_ONE) || (state_r == ST_FULL);
        m_valid_o = main_v_s & cke_i;
        s_ready_o = ready_r & cke_i;
        m_data_o  = main_data_r;
    end

endmodule

// File: tb/tb_iob_skid_reg_n.sv
// Self-checking bench for iob_skid_reg_n: a directed vector table with
// hand-derived expectations, a streaming sequence, a long random run
// against a queue-based reference model and, when the flush macro
// IOB_SKID_REG_N_FLUSH_EN is defined, a flush sequence.

module tb_iob_skid_reg_n;

    localparam int W = 21;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cke = 1'b1;
    logic         flush = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [W-1:0] s_data = '0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [W-1:0] m_data;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the buffer is just an ordered queue of at most two words.
    logic [W-1:0] q[$];
    bit           model_ok = 1'b0;
    int           pushed = 0;

    iob_skid_reg_n #(.DATA_W(W), .RST_VAL(21'h00005A)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .cke_i     (cke),
`ifdef IOB_SKID_REG_N_FLUSH_EN
        .flush_i   (flush),
`endif
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .s_data_i  (s_data),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_data_o  (m_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           rst_n;
        bit           cke;
        bit           sv;
        logic [W-1:0] sd;
        bit           mr;
        bit           chk;
        bit           exp_rdy;
        bit           exp_vld;
        bit           chk_data;
        logic [W-1:0] exp_data;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(bit r, bit c, bit sv, logic [W-1:0] sd, bit mr,
                                bit chk, bit er, bit ev, bit cd, logic [W-1:0] ed);
        vec_t v;
        v.rst_n = r; v.cke = c; v.sv = sv; v.sd = sd; v.mr = mr;
        v.chk = chk; v.exp_rdy = er; v.exp_vld = ev; v.chk_data = cd; v.exp_data = ed;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply inputs just after an edge, then compare outputs with the model.
    task automatic drive(input bit r, input bit c, input bit sv, input logic [W-1:0] sd,
                         input bit mr, input bit fl);
        rst_n = r; cke = c; s_valid = sv; s_data = sd; m_ready = mr; flush = fl;
        #1;
        if (model_ok) begin
            check("model_s_ready", {31'd0, s_ready}, {31'd0, (c && q.size() < 2)});
            check("model_m_valid", {31'd0, m_valid}, {31'd0, (c && q.size() > 0)});
            if (q.size() > 0) begin
                check("model_m_data", {11'd0, m_data}, {11'd0, q[0]});
            end
        end
    endtask

    // Advance one clock and update the model from the model's own handshakes.
    task automatic tick();
        bit er, ev, ix, ox;
        @(posedge clk);
        er = cke && (q.size() < 2);
        ev = cke && (q.size() > 0);
        ix = s_valid && er;
        ox = ev && m_ready;
        if (!rst_n) begin
            q.delete();
            model_ok = 1'b1;
        end else if (model_ok && cke) begin
            if (flush) begin
                q.delete();
            end else begin
                if (ox) void'(q.pop_front());
                if (ix) begin
                    q.push_back(s_data);
                    pushed++;
                end
            end
        end
        #1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, dut_pops, cyc;

        // rst cke sv data mr | chk rdy vld chk_data data
        tbl[0]  = mk(0, 1, 0, 21'h0,   0, 0, 0, 0, 0, 21'h0);
        tbl[1]  = mk(0, 1, 0, 21'h0,   0, 1, 1, 0, 1, 21'h5A);
        tbl[2]  = mk(0, 1, 0, 21'h0,   0, 1, 1, 0, 1, 21'h5A);
        tbl[3]  = mk(1, 1, 1, 21'hA1,  0, 1, 1, 0, 1, 21'h5A);
        tbl[4]  = mk(1, 1, 1, 21'hA2,  0, 1, 1, 1, 1, 21'hA1);
        tbl[5]  = mk(1, 1, 1, 21'hA3,  0, 1, 0, 1, 1, 21'hA1);
        tbl[6]  = mk(1, 1, 1, 21'hA3,  1, 1, 0, 1, 1, 21'hA1);
        tbl[7]  = mk(1, 1, 1, 21'hA3,  1, 1, 1, 1, 1, 21'hA2);
        tbl[8]  = mk(1, 1, 0, 21'h0,   1, 1, 1, 1, 1, 21'hA3);
        tbl[9]  = mk(1, 1, 1, 21'hB1,  0, 1, 1, 0, 0, 21'h0);
        tbl[10] = mk(1, 1, 1, 21'hB2,  0, 1, 1, 1, 1, 21'hB1);
        for (int i = 11; i < 16; i++) tbl[i] = mk(1, 0, 1, 21'hC1, 1, 1, 0, 0, 1, 21'hB1);
        tbl[16] = mk(1, 1, 0, 21'h0,   1, 1, 0, 1, 1, 21'hB1);
        tbl[17] = mk(1, 1, 0, 21'h0,   1, 1, 1, 1, 1, 21'hB2);
        tbl[18] = mk(1, 1, 1, 21'hD1,  0, 1, 1, 0, 0, 21'h0);
        tbl[19] = mk(0, 1, 1, 21'hD2,  1, 1, 1, 1, 1, 21'hD1);
        tbl[20] = mk(1, 1, 0, 21'h0,   0, 1, 1, 0, 1, 21'h5A);

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].rst_n, tbl[i].cke, tbl[i].sv, tbl[i].sd, tbl[i].mr, 1'b0);
            if (tbl[i].chk) begin
                check($sformatf("tbl%0d_s_ready", i), {31'd0, s_ready}, {31'd0, tbl[i].exp_rdy});
                check($sformatf("tbl%0d_m_valid", i), {31'd0, m_valid}, {31'd0, tbl[i].exp_vld});
                if (tbl[i].chk_data)
                    check($sformatf("tbl%0d_m_data", i), {11'd0, m_data}, {11'd0, tbl[i].exp_data});
            end
            tick();
        end

        // Streaming: one word per cycle, one-cycle latency, no bubbles.
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 1'b1, (i < 16), W'(i + 1), 1'b1, 1'b0);
            check("stream_s_ready", {31'd0, s_ready}, 32'd1);
            if (i >= 1 && i <= 16) begin
                check("stream_m_valid", {31'd0, m_valid}, 32'd1);
                check("stream_m_data", {11'd0, m_data}, i);
            end
            tick();
        end

        // Random valid/ready at 50% each until 10000 words are accepted.
        base = pushed;
        dut_pops = 0;
        cyc = 0;
        while ((pushed - base) < 10000 && cyc < 60000) begin
            drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            if (m_valid && m_ready) dut_pops++;
            tick();
            cyc++;
        end
        check("rand_words_accepted", pushed - base, 32'd10000);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
            if (m_valid && m_ready) dut_pops++;
            tick();
        end
        check("rand_words_delivered", dut_pops, 32'd10000);
        drive(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("rand_drained_valid", {31'd0, m_valid}, 32'd0);
        tick();

`ifdef IOB_SKID_REG_N_FLUSH_EN
        // Flush while FULL with a word offered and consumer ready.
        drive(1'b1, 1'b1, 1'b1, 21'hE1, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b1, 21'hE2, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b1, 21'hE3, 1'b1, 1'b1);
        check("flush_pre_ready", {31'd0, s_ready}, 32'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("flush_m_valid", {31'd0, m_valid}, 32'd0);
        check("flush_s_ready", {31'd0, s_ready}, 32'd1);
        tick();
        drive(1'b1, 1'b1, 1'b1, 21'h77, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        check("flush_77_valid", {31'd0, m_valid}, 32'd1);
        check("flush_77_data", {11'd0, m_data}, 32'h77);
        tick();
        drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        check("flush_77_alone", {31'd0, m_valid}, 32'd0);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/iob_skid_reg_n.md
# iob_skid_reg_n

Two-entry ready/valid pipeline register (skid buffer) for the consumer side of enabled-register datapaths. A producer writes words under a valid/ready handshake, and the downstream consumer releases them through its own handshake. All outputs are registered, so the block cuts timing on both the forward data/valid path and the backward ready path. It sits between any two pipeline stages that exchange words under valid/ready flow control.

## Interface
Parameters:
- DATA_W, 21, data word width in bits (≥1).
- RST_VAL, 0, value of both data registers after reset.

Ports:
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_n_i  input  1  reset, synchronous, active-low.
- cke_i  input  1  clock enable; when 0, all state is frozen.
- s_valid_i  input  1  producer offers s_data_i.
- s_ready_o  output  1  block can accept a word.
- s_data_i  input  DATA_W  producer word.
- m_valid_o  output  1  m_data_o holds a valid word.
- m_ready_i  input  1  consumer accepts m_data_o.
- m_data_o  output  DATA_W  oldest stored word.

## Operation
- Storage: main register (drives m_data_o) and skid register. Valid bits: main_v, skid_v.
- Occupancy states:
  - EMPTY: main_v=0, skid_v=0.
  - ONE: main_v=1, skid_v=0.
  - FULL: main_v=1, skid_v=1.
- Internal ready_r = !skid_v, registered.
- Outputs: s_ready_o = ready_r & cke_i; m_valid_o = main_v & cke_i.
- Handshakes:
  - Input transfer (in_xfer) = s_valid_i & s_ready_o.
  - Output transfer (out_xfer) = m_valid_o & m_ready_i.
  - Neither is counted while cke_i=0.
- Transitions, evaluated only when cke_i=1:
  - EMPTY, in_xfer: main ← s_data_i; go to ONE.
  - ONE, in_xfer and no out_xfer: skid ← s_data_i; go to FULL, so ready_r falls next cycle.
  - ONE, in_xfer and out_xfer: main ← s_data_i; stay in ONE.
  - ONE, out_xfer only: go to EMPTY.
  - FULL, out_xfer: main ← skid; go to ONE. No in_xfer is possible in FULL.
  - FULL, no out_xfer: hold.
- Order and integrity: words leave in arrival order. No word is dropped or duplicated.
- m_data_o is stable while m_valid_o=1 and m_ready_i=0.
- Data registers keep stale contents when their valid bit is 0. Only the valid bits are architecturally meaningful.

## Timing
- Reset, while rst_n_i=0 at a clock edge:
  - main_v=0, skid_v=0, ready_r=1.
  - Both data registers load RST_VAL.
  - After the first clock with reset asserted: m_valid_o=0, m_data_o=RST_VAL, s_ready_o=cke_i.
- Reset overrides cke_i, handshakes, and flush.
- Reset mid-operation discards all stored words. No out_xfer is reported on that edge.
- Latency: a word accepted at edge N appears on m_data_o with m_valid_o=1 after edge N. That is 1 cycle in EMPTY, or behind the older words otherwise.
- Throughput: one word per cycle sustained when m_ready_i=1 continuously.
- Backpressure: s_ready_o falls one cycle after the skid register fills. It rises one cycle after an out_xfer from FULL.
- No combinational path from m_ready_i to s_ready_o, or from s_valid_i/s_data_i to m_valid_o/m_data_o. cke_i gating is the only combinational term on the outputs.

## Configuration
- Macro: IOB_SKID_REG_N_FLUSH_EN.
- Defined:
  - Adds port flush_i (input, 1, synchronous flush, active-high).
  - When flush_i=1 and cke_i=1 at an edge: main_v=0, skid_v=0, ready_r=1. Data registers are unchanged.
  - Any in_xfer or out_xfer in that same cycle is discarded; the word is neither stored nor counted.
  - Flush has priority over handshakes; reset has priority over flush.
- Undefined: the port is absent and the flush logic is not synthesized.

## Test plan
- Reset: hold rst_n_i=0 for 3 cycles with RST_VAL=0x5A, cke_i=1 -> m_valid_o=0, m_data_o=0x5A, s_ready_o=1.
- Streaming: m_ready_i=1, push 0x01..0x10 on consecutive cycles -> same sequence on m_data_o, 1-cycle latency, no bubbles, s_ready_o always 1.
- Backpressure: m_ready_i=0, push 0xA1, 0xA2, 0xA3 -> 0xA1 in main, 0xA2 in skid, s_ready_o=0 from the cycle after 0xA2, 0xA3 held by the producer. Release m_ready_i -> output order 0xA1, 0xA2, 0xA3.
- Random valid/ready at 50% each, 10000 words -> scoreboard shows exact order, no loss or duplication, and m_data_o stable while stalled.
- cke_i=0 for 5 cycles while FULL with m_ready_i=1 -> m_valid_o=0, s_ready_o=0, state unchanged. Resume -> 2 words delivered in order.
- With IOB_SKID_REG_N_FLUSH_EN: fill to FULL, pulse flush_i with s_valid_i=1 -> next cycle m_valid_o=0, s_ready_o=1, the offered word is not stored. A subsequent push of 0x77 appears alone.
